// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_ctrl
// Brief    : Sequencing controller for the SHA-256 compression datapath.
//            Accepts padded 512-bit blocks, drives init/ready/digest_update/
//            done strobes, supplies the round index for the W scheduler and
//            K ROM, and holds the final digest until it is acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_round_ctrl #(
  parameter int ROUNDS    = 64,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 block_valid,
  input  logic                 block_last,
  output logic                 block_ready,
  output logic                 blk_load,
  output logic                 init,
  output logic                 ready,
  output logic                 digest_update,
  output logic                 done,
  output logic [5:0]           round_idx,
  output logic                 busy,
  output logic                 digest_valid,
  input  logic                 digest_ack,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_ROUND  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [5:0]           C_LAST_ROUND = 6'(ROUNDS - 1);
  localparam logic [BLK_CNT_W-1:0] C_BLK_MAX    = '1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;
  logic       r_first;
  logic       w_first_nxt;
  logic       r_last;
  logic       w_hs;

  // block_ready is only ever high in IDLE; reset blocks acceptance outright
  assign w_hs     = block_valid && block_ready && (r_state == S_IDLE) && !reset;
  assign blk_load = w_hs;

  // Next-state, round counter and first-block flag
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_cnt_nxt   = 6'd0;
          w_state_nxt = r_first ? S_INIT : S_ROUND;
        end
      end
      S_INIT: begin
        w_first_nxt = 1'b0;
        w_cnt_nxt   = 6'd0;
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (r_cnt == C_LAST_ROUND) begin
          w_cnt_nxt   = 6'd0;
          w_state_nxt = S_UPDATE;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      S_UPDATE: begin
        w_state_nxt = r_last ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (digest_ack) begin
          w_first_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  // State register plus Moore outputs decoded from the upcoming state so they are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 6'd0;
      r_first       <= 1'b1;
      r_last        <= 1'b0;
      blk_cnt       <= '0;
      block_ready   <= 1'b0;
      init          <= 1'b0;
      ready         <= 1'b0;
      digest_update <= 1'b0;
      done          <= 1'b0;
      digest_valid  <= 1'b0;
      busy          <= 1'b0;
      round_idx     <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      if (w_hs) begin
        r_last <= block_last;
      end
      // Count restarts with a new message; saturates rather than wrapping
      if (r_state == S_INIT) begin
        blk_cnt <= '0;
      end else if (r_state == S_UPDATE && blk_cnt != C_BLK_MAX) begin
        blk_cnt <= blk_cnt + 1'b1;
      end
      block_ready   <= (w_state_nxt == S_IDLE);
      init          <= (w_state_nxt == S_INIT);
      ready         <= (w_state_nxt == S_ROUND);
      digest_update <= (w_state_nxt == S_UPDATE);
      done          <= (w_state_nxt == S_DONE);
      digest_valid  <= (w_state_nxt == S_DONE);
      busy          <= (w_state_nxt == S_INIT) || (w_state_nxt == S_ROUND) ||
                       (w_state_nxt == S_UPDATE) ||
                       ((w_state_nxt == S_IDLE) && !w_first_nxt);
      round_idx     <= (w_state_nxt == S_ROUND) ? w_cnt_nxt : 6'd0;
    end
  end

endmodule
`default_nettype wire
